// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and hex key output.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN (adds REPEAT_CYCLES).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 12000,
  parameter int unsigned DEBOUNCE_CYCLES = 240000
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 6000000
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ZERO  = {DB_W{1'b0}};
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
`endif

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       col_r, col_s;
  logic [1:0]       row_r, row_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [DB_W-1:0]  db_cnt_r, db_cnt_s;
  logic [3:0]       key_r, key_s;
  logic             key_valid_r, key_valid_s;
  logic             key_held_r, key_held_s;
  logic [3:0]       cols_r, cols_s;
  logic [3:0]       rows_meta_r, rows_sync_r;
  logic             row_high_s;
`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
`endif

  // Lowest-index low row wins when several keys share the scanned column.
  function automatic logic [1:0] lowest_low(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0]) begin
      idx = 2'd0;
    end else if (!v[1]) begin
      idx = 2'd1;
    end else if (!v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta_r <= 4'b1111;
      rows_sync_r <= 4'b1111;
    end else begin
      rows_meta_r <= rows;
      rows_sync_r <= rows_meta_r;
    end
  end

  assign row_high_s = rows_sync_r[row_r];

  // Next-state and next-output logic for the scan/debounce FSM.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    div_s       = div_r;
    db_cnt_s    = db_cnt_r;
    key_s       = key_r;
    key_valid_s = 1'b0;
    key_held_s  = key_held_r;
`ifdef KEY_REPEAT_EN
    rep_cnt_s   = rep_cnt_r;
`endif
    case (state_r)
      ST_SCAN: begin
        key_held_s = 1'b0;
        if (div_r == DIV_LAST) begin
          div_s = DIV_ZERO;
          if (rows_sync_r != 4'b1111) begin
            row_s    = lowest_low(rows_sync_r);
            db_cnt_s = DB_ZERO;
            state_s  = ST_PRESS_DB;
          end else begin
            col_s = col_r + 2'd1;
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      ST_PRESS_DB: begin
        if (row_high_s) begin
          state_s = ST_SCAN;
          col_s   = col_r + 2'd1;
          div_s   = DIV_ZERO;
        end else if (db_cnt_r == DB_LAST) begin
          key_s       = key_map(row_r, col_r);
          key_valid_s = 1'b1;
          key_held_s  = 1'b1;
          state_s     = ST_HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_s   = REP_ZERO;
`endif
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end
      ST_HELD: begin
        key_held_s = 1'b1;
        if (row_high_s) begin
          state_s  = ST_REL_DB;
          db_cnt_s = DB_ZERO;
`ifdef KEY_REPEAT_EN
          rep_cnt_s = REP_ZERO;
`endif
        end else begin
`ifdef KEY_REPEAT_EN
          // Repeat period is measured only over uninterrupted time in HELD.
          if (rep_cnt_r == REP_LAST) begin
            key_valid_s = 1'b1;
            rep_cnt_s   = REP_ZERO;
          end else begin
            rep_cnt_s = rep_cnt_r + REP_ONE;
          end
`else
          state_s = ST_HELD;
`endif
        end
      end
      ST_REL_DB: begin
        if (!row_high_s) begin
          state_s = ST_HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_s = REP_ZERO;
`endif
        end else if (db_cnt_r == DB_LAST) begin
          key_held_s = 1'b0;
          col_s      = col_r + 2'd1;
          div_s      = DIV_ZERO;
          state_s    = ST_SCAN;
        end else begin
          db_cnt_s = db_cnt_r + DB_ONE;
        end
      end
      default: begin
        state_s    = ST_SCAN;
        col_s      = 2'd0;
        div_s      = DIV_ZERO;
        db_cnt_s   = DB_ZERO;
        key_held_s = 1'b0;
      end
    endcase
    cols_s = ~(4'b0001 << col_s);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_SCAN;
      col_r       <= 2'd0;
      row_r       <= 2'd0;
      div_r       <= DIV_ZERO;
      db_cnt_r    <= DB_ZERO;
      key_r       <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
      cols_r      <= 4'b1110;
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      row_r       <= row_s;
      div_r       <= div_s;
      db_cnt_r    <= db_cnt_s;
      key_r       <= key_s;
      key_valid_r <= key_valid_s;
      key_held_r  <= key_held_s;
      cols_r      <= cols_s;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counter, present only in repeat builds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_r <= REP_ZERO;
    end else begin
      rep_cnt_r <= rep_cnt_s;
    end
  end
`endif

  assign cols      = cols_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed steps plus random row patterns,
// compared every cycle against a run-length behavioural model of the keypad rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
`ifdef KEY_REPEAT_EN
  localparam int REP      = 32;
`endif
  localparam int P_SCAN  = 0;
  localparam int P_PRESS = 1;
  localparam int P_HELD  = 2;
  localparam int P_REL   = 3;

  logic       clk;
  logic       reset_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  int total;
  int bad;
  int dut_pulses;

  // behavioural model state
  logic [3:0] m_s1, m_rs, m_key;
  logic       m_valid, m_held;
  int         m_phase, m_col, m_row, m_div, m_run, m_rep;
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_CYCLES(REP)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rows(rows),
    .cols(cols),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) return i;
    end
    return 3;
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_rs = 4'hF; m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    m_phase = P_SCAN; m_col = 0; m_row = 0; m_div = 0; m_run = 0; m_rep = 0;
  endtask

  // One clock edge of the keypad rules, using the rows seen at that edge.
  task automatic model_step();
    logic [3:0] rs_now;
    if (!reset_n) begin
      model_reset();
      return;
    end
    rs_now  = m_rs;
    m_valid = 1'b0;
    case (m_phase)
      P_SCAN: begin
        m_div++;
        if (m_div == SCAN_DIV) begin
          m_div = 0;
          if (rs_now != 4'hF) begin
            m_row = first_low(rs_now); m_run = 0; m_phase = P_PRESS;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
      end
      P_PRESS: begin
        if (rs_now[m_row]) begin
          m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_div = 0;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_key = kmap[m_row*4 + m_col]; m_valid = 1'b1; m_held = 1'b1;
            m_phase = P_HELD; m_rep = 0;
          end
        end
      end
      P_HELD: begin
        if (rs_now[m_row]) begin
          m_phase = P_REL; m_run = 0; m_rep = 0;
        end else begin
`ifdef KEY_REPEAT_EN
          m_rep++;
          if (m_rep == REP) begin
            m_valid = 1'b1; m_rep = 0;
          end
`endif
        end
      end
      default: begin
        if (!rs_now[m_row]) begin
          m_phase = P_HELD; m_rep = 0;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_held = 1'b0; m_col = (m_col + 1) % 4; m_div = 0; m_phase = P_SCAN;
          end
        end
      end
    endcase
    m_rs = m_s1;
    m_s1 = rows;
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = 4'b1111;
    ec[m_col] = 1'b0;
    check("cols", 32'(cols), 32'(ec));
    check("key", 32'(key), 32'(m_key));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held", 32'(key_held), 32'(m_held));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (key_valid === 1'b1) dut_pulses++;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_col(input int c);
    int n;
    n = 0;
    while (!(m_phase == P_SCAN && m_col == c && m_div == 0) && n < 64) begin
      tick();
      n++;
    end
    total++;
    assert (m_phase == P_SCAN && m_col == c && m_div == 0) else begin
      bad++;
      $error("FAIL wait_col timeout observed_col=%0d expected_col=%0d", m_col, c);
    end
  endtask

  task automatic async_reset_check(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_cols"}, 32'(cols), 32'h0000000E);
    check({tag, "_key"}, 32'(key), 32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_held"}, 32'(key_held), 32'h0);
    model_reset();
    ticks(2);
    rows = 4'hF;
    reset_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; rows = 4'hF;
    total = 0; bad = 0; dut_pulses = 0;
    model_reset();
    ticks(2);
    check("rst_cols", 32'(cols), 32'h0000000E);
    check("rst_key", 32'(key), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    reset_n = 1'b1;

    // idle scanning
    dut_pulses = 0;
    ticks(40);
    check("idle_pulses", 32'(dut_pulses), 32'd0);

    // key 6: row1 at col2
    wait_col(2);
    dut_pulses = 0;
    rows = 4'b1101;
    ticks(20);
    check("k6_pulses", 32'(dut_pulses), 32'd1);
    check("k6_key", 32'(key), 32'h6);
    check("k6_held", 32'(key_held), 32'h1);
    check("k6_cols", 32'(cols), 32'hB);
    rows = 4'hF;
    ticks(20);

    // short bounce on row3 at col1
    wait_col(1);
    dut_pulses = 0;
    rows = 4'b0111;
    ticks(3);
    rows = 4'hF;
    ticks(3);
    check("short_pulses", 32'(dut_pulses), 32'd0);
    check("short_cols", 32'(cols), 32'hB);

    // key A with a release bounce
    wait_col(3);
    dut_pulses = 0;
    rows = 4'b1110;
    ticks(16);
    rows = 4'hF;
    ticks(2);
    rows = 4'b1110;
    ticks(6);
    check("kA_held_bounce", 32'(key_held), 32'h1);
    rows = 4'hF;
    ticks(12);
    check("kA_pulses", 32'(dut_pulses), 32'd1);
    check("kA_key", 32'(key), 32'hA);
    check("kA_held_end", 32'(key_held), 32'h0);
    check("kA_cols", 32'(cols), 32'hE);

    // two rows at col0, then other key activity while held
    wait_col(0);
    dut_pulses = 0;
    rows = 4'b1010;
    ticks(16);
    rows = 4'b1110;
    ticks(3);
    rows = 4'b1010;
    ticks(3);
    check("k1_pulses", 32'(dut_pulses), 32'd1);
    check("k1_key", 32'(key), 32'h1);
    check("k1_held", 32'(key_held), 32'h1);
    rows = 4'hF;
    ticks(14);

    // reset mid press-debounce and mid held
    wait_col(1);
    rows = 4'b1011;
    ticks(7);
    async_reset_check("rst_pdb");
    wait_col(3);
    rows = 4'b0111;
    ticks(16);
    check("kD_key", 32'(key), 32'hD);
    check("kD_held", 32'(key_held), 32'h1);
    async_reset_check("rst_held");

    // long hold of key 5
    wait_col(1);
    dut_pulses = 0;
    rows = 4'b1101;
    ticks(115);
    rows = 4'hF;
    ticks(14);
`ifdef KEY_REPEAT_EN
    check("k5_pulses", 32'(dut_pulses), 32'd4);
`else
    check("k5_pulses", 32'(dut_pulses), 32'd1);
`endif
    check("k5_key", 32'(key), 32'h5);

    // random row activity with occasional resets
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        rows = 4'hF;
      end else begin
        rows = 4'($urandom);
      end
      ticks(int'($urandom_range(1, 40)));
      if ($urandom_range(0, 15) == 0) begin
        async_reset_check("rst_rand");
      end
    end
    rows = 4'hF;
    ticks(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
